// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the 8259 in-service control slice.
//   - isc_state_e      : acknowledge-sequence FSM states
//   - OCW2 command codes ({R, SL, EOI})
//   - SPURIOUS_LEVEL   : level reported when no request is present at the first INTA
//   - level_to_onehot / onehot_to_level helpers
package pic_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      ACK1  = 3'd2,
      WAIT2 = 3'd3,
      ACK2  = 3'd4
   } isc_state_e;

   localparam logic [2:0] EOI_NS       = 3'b001;
   localparam logic [2:0] EOI_SP       = 3'b011;
   localparam logic [2:0] ROT_NS       = 3'b101;
   localparam logic [2:0] ROT_SP       = 3'b111;
   localparam logic [2:0] SET_PRI      = 3'b110;
   localparam logic [2:0] ROT_AEOI_SET = 3'b100;
   localparam logic [2:0] ROT_AEOI_CLR = 3'b000;

   localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

   function automatic logic [7:0] level_to_onehot(input logic [2:0] level);
      return 8'h01 << level;
   endfunction

   // Lowest set bit wins if the input is not strictly one-hot.
   function automatic logic [2:0] onehot_to_level(input logic [7:0] onehot);
      logic [2:0] lvl;
      lvl = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (onehot[i]) begin
            lvl = 3'(i);
         end else begin
            lvl = lvl;
         end
      end
      return lvl;
   endfunction

endpackage

// File: rtl/in_service_control_if.sv
// in_service_control_if: bus between the CPU/resolver side and in_service_control.
//   Inputs to the block : interrupt, inta_n, vector_base, aeoi_mode,
//                         ocw2_valid, ocw2_cmd, ocw2_level
//   Outputs of the block: int_out, in_service_register, priority_rotate,
//                         clear_request, data_out, data_out_en
//   modport master: environment side (drives requests/commands)
//   modport slave : in_service_control side
interface in_service_control_if;
   logic [7:0] interrupt;
   logic       inta_n;
   logic [4:0] vector_base;
   logic       aeoi_mode;
   logic       ocw2_valid;
   logic [2:0] ocw2_cmd;
   logic [2:0] ocw2_level;

   logic       int_out;
   logic [7:0] in_service_register;
   logic [2:0] priority_rotate;
   logic [7:0] clear_request;
   logic [7:0] data_out;
   logic       data_out_en;

   modport master (
      output interrupt, inta_n, vector_base, aeoi_mode,
             ocw2_valid, ocw2_cmd, ocw2_level,
      input  int_out, in_service_register, priority_rotate,
             clear_request, data_out, data_out_en
   );

   modport slave (
      input  interrupt, inta_n, vector_base, aeoi_mode,
             ocw2_valid, ocw2_cmd, ocw2_level,
      output int_out, in_service_register, priority_rotate,
             clear_request, data_out, data_out_en
   );
endinterface

// File: rtl/highest_in_service.sv
// highest_in_service: combinational search of the ISR for the highest-priority
// set bit, starting at priority_rotate and wrapping mod 8.
//   isr             in  8  in-service register
//   priority_rotate in  3  level with highest priority
//   one_hot         out 8  selected bit (zero when none found)
//   level           out 3  selected level (0 when none found)
//   found           out 1  any ISR bit set
module highest_in_service
   import pic_pkg::*;
(
   input  logic [7:0] isr,
   input  logic [2:0] priority_rotate,
   output logic [7:0] one_hot,
   output logic [2:0] level,
   output logic       found
);

   logic [2:0] idx_s;

   // Walk the eight levels in priority order; first set bit is the winner.
   always_comb begin
      one_hot = 8'h00;
      level   = 3'd0;
      found   = 1'b0;
      idx_s   = 3'd0;
      for (int i = 0; i < 8; i++) begin
         idx_s = priority_rotate + 3'(i);
         if (!found && isr[idx_s]) begin
            found = 1'b1;
            level = idx_s;
         end else begin
            found = found;
         end
      end
      if (found) begin
         one_hot = level_to_onehot(level);
      end else begin
         one_hot = 8'h00;
      end
   end

endmodule

// File: rtl/in_service_control.sv
// in_service_control: 8259 INT/INTA sequencing, In-Service Register and OCW2
// EOI/rotation handling (8086 two-pulse acknowledge).
//   clk, reset (sync, active-high) : plain ports
//   bus (in_service_control_if.slave): request, INTA, ICW/OCW2 inputs and the
//       registered INT, ISR, priority_rotate, clear_request, vector outputs.
// Build option: define PIC_AEOI_EN to enable automatic EOI (aeoi_mode) and the
// rotate-in-AEOI set/clear commands; otherwise those inputs/commands are ignored.
module in_service_control
   import pic_pkg::*;
#(
   parameter int INTA_PULSES = 2
)(
   input  logic                    clk,
   input  logic                    reset,
   in_service_control_if.slave     bus
);

   // Only the two-pulse sequence exists; any other value degenerates to one pulse.
   localparam bit TWO_PULSE_C = (INTA_PULSES == 2);

   isc_state_e state_r, state_nxt_s;

   logic       inta_prev_r;
   logic       fall_s, rise_s;
   logic       ack_s, aeoi_done_s, aeoi_active_s, rotate_aeoi_s;
   logic [2:0] ack_level_s;
   logic [7:0] set_s;

   logic [2:0] level_r, level_nxt_s;
   logic [7:0] isr_r, isr_nxt_s;
   logic [2:0] rot_r, rot_nxt_s;
   logic [7:0] clear_r, clear_nxt_s;
   logic [7:0] data_r, data_nxt_s;
   logic       en_r, en_nxt_s;
   logic       int_r, int_nxt_s;

   logic [7:0] ocw_clr_s, aeoi_clr_s;
   logic       ocw_rot_en_s;
   logic [2:0] ocw_rot_s;

   logic [7:0] hs_onehot_s;
   logic [2:0] hs_level_s;
   logic       hs_found_s;

   highest_in_service u_highest (
      .isr             (isr_r),
      .priority_rotate (rot_r),
      .one_hot         (hs_onehot_s),
      .level           (hs_level_s),
      .found           (hs_found_s)
   );

   assign fall_s      = inta_prev_r & ~bus.inta_n;
   assign rise_s      = ~inta_prev_r & bus.inta_n;
   assign ack_s       = (state_r == REQ) && fall_s;
   assign aeoi_done_s = (state_r == ACK2) && rise_s;
   // A request that vanished before the first INTA is acknowledged as spurious.
   assign ack_level_s = (bus.interrupt != 8'h00) ? onehot_to_level(bus.interrupt) : SPURIOUS_LEVEL;
   assign set_s       = (ack_s && (bus.interrupt != 8'h00)) ? level_to_onehot(ack_level_s) : 8'h00;

`ifdef PIC_AEOI_EN
   logic rotate_aeoi_r;

   assign aeoi_active_s = bus.aeoi_mode;
   assign rotate_aeoi_s = rotate_aeoi_r;

   // Rotate-in-AEOI flag, set/cleared by OCW2 100/000.
   always_ff @(posedge clk) begin
      if (reset) begin
         rotate_aeoi_r <= 1'b0;
      end else if (bus.ocw2_valid && (bus.ocw2_cmd == ROT_AEOI_SET)) begin
         rotate_aeoi_r <= 1'b1;
      end else if (bus.ocw2_valid && (bus.ocw2_cmd == ROT_AEOI_CLR)) begin
         rotate_aeoi_r <= 1'b0;
      end else begin
         rotate_aeoi_r <= rotate_aeoi_r;
      end
   end
`else
   logic unused_aeoi_s;

   assign aeoi_active_s = 1'b0;
   assign rotate_aeoi_s = 1'b0;
   assign unused_aeoi_s = bus.aeoi_mode;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.interrupt != 8'h00) state_nxt_s = REQ;
            else                        state_nxt_s = IDLE;
         end
         REQ: begin
            if (fall_s) state_nxt_s = ACK1;
            else        state_nxt_s = REQ;
         end
         ACK1: begin
            if (rise_s) state_nxt_s = TWO_PULSE_C ? WAIT2 : IDLE;
            else        state_nxt_s = ACK1;
         end
         WAIT2: begin
            if (fall_s) state_nxt_s = ACK2;
            else        state_nxt_s = WAIT2;
         end
         ACK2: begin
            if (rise_s) state_nxt_s = IDLE;
            else        state_nxt_s = ACK2;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // OCW2 decode: which ISR bit to clear and whether priority moves.
   always_comb begin
      ocw_clr_s    = 8'h00;
      ocw_rot_en_s = 1'b0;
      ocw_rot_s    = rot_r;
      if (bus.ocw2_valid) begin
         case (bus.ocw2_cmd)
            EOI_NS: ocw_clr_s = hs_onehot_s;
            EOI_SP: ocw_clr_s = level_to_onehot(bus.ocw2_level);
            ROT_NS: begin
               ocw_clr_s = hs_onehot_s;
               if (hs_found_s) begin
                  ocw_rot_en_s = 1'b1;
                  ocw_rot_s    = hs_level_s + 3'd1;
               end else begin
                  ocw_rot_en_s = 1'b0;
               end
            end
            ROT_SP: begin
               ocw_clr_s    = level_to_onehot(bus.ocw2_level);
               ocw_rot_en_s = 1'b1;
               ocw_rot_s    = bus.ocw2_level + 3'd1;
            end
            SET_PRI: begin
               ocw_rot_en_s = 1'b1;
               ocw_rot_s    = bus.ocw2_level + 3'd1;
            end
            default: ocw_clr_s = 8'h00;
         endcase
      end else begin
         ocw_clr_s = 8'h00;
      end
   end

   // Output/next-value logic for every registered output.
   always_comb begin
      int_nxt_s   = (state_nxt_s == REQ);
      clear_nxt_s = set_s;
      level_nxt_s = level_r;
      aeoi_clr_s  = 8'h00;
      rot_nxt_s   = rot_r;

      if (ack_s) level_nxt_s = ack_level_s;
      else       level_nxt_s = level_r;

      if (aeoi_done_s && aeoi_active_s) begin
         aeoi_clr_s = level_to_onehot(level_r);
         if (rotate_aeoi_s) rot_nxt_s = level_r + 3'd1;
         else               rot_nxt_s = rot_r;
      end else begin
         aeoi_clr_s = 8'h00;
      end

      // An explicit OCW2 priority change takes precedence over AEOI rotation.
      if (ocw_rot_en_s) rot_nxt_s = ocw_rot_s;
      else              rot_nxt_s = rot_nxt_s;

      // Clears come from the pre-cycle ISR; a same-cycle acknowledge set wins.
      isr_nxt_s = (isr_r & ~ocw_clr_s & ~aeoi_clr_s) | set_s;

      en_nxt_s = (state_nxt_s == ACK2) && !bus.inta_n;
      if (en_nxt_s) data_nxt_s = {bus.vector_base, level_r};
      else          data_nxt_s = 8'h00;
   end

   // Output and datapath registers, plus the INTA edge-detect history.
   always_ff @(posedge clk) begin
      if (reset) begin
         inta_prev_r <= 1'b1;
         level_r     <= 3'd0;
         isr_r       <= 8'h00;
         rot_r       <= 3'd0;
         clear_r     <= 8'h00;
         data_r      <= 8'h00;
         en_r        <= 1'b0;
         int_r       <= 1'b0;
      end else begin
         inta_prev_r <= bus.inta_n;
         level_r     <= level_nxt_s;
         isr_r       <= isr_nxt_s;
         rot_r       <= rot_nxt_s;
         clear_r     <= clear_nxt_s;
         data_r      <= data_nxt_s;
         en_r        <= en_nxt_s;
         int_r       <= int_nxt_s;
      end
   end

   assign bus.int_out             = int_r;
   assign bus.in_service_register = isr_r;
   assign bus.priority_rotate     = rot_r;
   assign bus.clear_request       = clear_r;
   assign bus.data_out            = data_r;
   assign bus.data_out_en         = en_r;

endmodule
